// File: rtl/mul_restore_if.sv
// mul_restore_if: Start/Done handshake and operand/result bus for the
// shift-add multiply-accumulate unit (Prod = q*b + r).
interface mul_restore_if;
   logic       Start;
   logic [3:0] q;
   logic [3:0] b;
   logic [3:0] r;
   logic       Busy;
   logic       Done;
   logic [7:0] Prod;
   logic       Err;

   // Requester side: issues operands, observes status and result
   modport master (
      output Start, q, b, r,
      input  Busy, Done, Prod, Err
   );

   // Multiplier side
   modport slave (
      input  Start, q, b, r,
      output Busy, Done, Prod, Err
   );
endinterface

// File: rtl/mul_restore.sv
// mul_restore: sequential 4x4 shift-add multiply-accumulate, Prod = q*b + r.
// Rebuilds a dividend from the 4-bit divider's quotient/remainder/divisor.
// Fixed latency of four iterations, Start/Done handshake.
// Optional build macro MUL_RESTORE_CHECK_EN: when defined, Err flags a zero
// divisor or a remainder not smaller than the divisor; when undefined, Err is 0.
module mul_restore (
   input  logic       Clk,
   input  logic       Rst,
   mul_restore_if.slave bus
);

   typedef enum logic {IDLE, MUL} state_t;

   state_t     state_reg, state_next;
   logic [3:0] mplier_reg, mplier_next;
   logic [7:0] mcand_reg, mcand_next;
   logic [7:0] acc_reg, acc_next;
   logic [1:0] cnt_reg, cnt_next;
   logic [7:0] prod_reg, prod_next;
   logic       busy_reg, busy_next;
   logic       done_reg, done_next;
   logic [7:0] sum;

`ifdef MUL_RESTORE_CHECK_EN
   logic       err_reg, err_next;
   logic       err_calc;

   // Operand consistency: zero divisor or remainder out of range
   always_comb begin
      err_calc = (bus.b == 4'd0) || (bus.r >= bus.b);
   end

   // Err register, updated only when an operation is accepted
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) err_reg <= 1'b0;
      else     err_reg <= err_next;
   end

   // Capture the consistency result on the accepting edge
   always_comb begin
      err_next = err_reg;
      if (state_reg == IDLE && bus.Start) err_next = err_calc;
   end

   assign bus.Err = err_reg;
`else
   assign bus.Err = 1'b0;
`endif

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_reg  <= IDLE;
         mplier_reg <= 4'd0;
         mcand_reg  <= 8'd0;
         acc_reg    <= 8'd0;
         cnt_reg    <= 2'd0;
         prod_reg   <= 8'd0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         mplier_reg <= mplier_next;
         mcand_reg  <= mcand_next;
         acc_reg    <= acc_next;
         cnt_reg    <= cnt_next;
         prod_reg   <= prod_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
      end
   end

   // Next-state and datapath: accept in IDLE, one shift-add per MUL cycle
   always_comb begin
      state_next  = state_reg;
      mplier_next = mplier_reg;
      mcand_next  = mcand_reg;
      acc_next    = acc_reg;
      cnt_next    = cnt_reg;
      prod_next   = prod_reg;
      busy_next   = busy_reg;
      done_next   = done_reg;
      // 15*15+15 = 240 fits in 8 bits, so no carry-out is needed
      sum         = acc_reg + (mplier_reg[0] ? mcand_reg : 8'd0);

      case (state_reg)
         IDLE: begin
            if (bus.Start) begin
               mplier_next = bus.q;
               mcand_next  = {4'b0000, bus.b};
               acc_next    = {4'b0000, bus.r};
               cnt_next    = 2'd0;
               done_next   = 1'b0;
               busy_next   = 1'b1;
               state_next  = MUL;
            end
         end
         MUL: begin
            acc_next    = sum;
            mcand_next  = {mcand_reg[6:0], 1'b0};
            mplier_next = {1'b0, mplier_reg[3:1]};
            cnt_next    = cnt_reg + 2'd1;
            // Always four iterations, even for a zero multiplicand
            if (cnt_reg == 2'd3) begin
               prod_next  = sum;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.Busy = busy_reg;
   assign bus.Done = done_reg;
   assign bus.Prod = prod_reg;

endmodule

// File: tb/tb_mul_restore.sv
// tb_mul_restore: randomized and directed checks of mul_restore against an
// arithmetic model (q*b + r, consistency flag from the divisor/remainder rule).
module tb_mul_restore;

   logic Clk;
   logic Rst;
   int   checks;
   int   errors;
   logic [7:0] last_prod;

   mul_restore_if bus ();

   mul_restore dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [7:0] model_prod(input logic [3:0] qi, bi, ri);
      int v;
      v = int'(qi) * int'(bi) + int'(ri);
      return v[7:0];
   endfunction

   function automatic logic model_err(input logic [3:0] bi, ri);
`ifdef MUL_RESTORE_CHECK_EN
      return (bi == 4'd0) || (ri >= bi);
`else
      return 1'b0;
`endif
   endfunction

   // One full operation from IDLE: accept, four busy cycles, Done with result
   task automatic run_op(input logic [3:0] qi, bi, ri, input string name);
      logic [7:0] exp_p;
      logic       exp_e;
      exp_p = model_prod(qi, bi, ri);
      exp_e = model_err(bi, ri);
      bus.Start = 1'b1; bus.q = qi; bus.b = bi; bus.r = ri;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      bus.q = 4'($urandom_range(0, 15));
      bus.b = 4'($urandom_range(0, 15));
      bus.r = 4'($urandom_range(0, 15));
      checks++;
      if (bus.Done !== 1'b0 || bus.Prod !== last_prod) begin
         errors++;
         $display("FAIL %s accept: done=%0b prod=%0d expected done=0 prod=%0d", name, bus.Done, bus.Prod, last_prod);
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin @(posedge Clk); #1; end
         checks++;
         if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL %s busy%0d: busy=%0b done=%0b expected busy=1 done=0", name, i, bus.Busy, bus.Done);
         end
      end
      @(posedge Clk); #1;
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b1 || bus.Prod !== exp_p || bus.Err !== exp_e) begin
         errors++;
         $display("FAIL %s result: busy=%0b done=%0b prod=%0d err=%0b expected busy=0 done=1 prod=%0d err=%0b",
                  name, bus.Busy, bus.Done, bus.Prod, bus.Err, exp_p, exp_e);
      end
      last_prod = exp_p;
      $display("op %s q=%0d b=%0d r=%0d prod=%0d err=%0b", name, qi, bi, ri, bus.Prod, bus.Err);
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Prod !== 8'h00 || bus.Err !== 1'b0) begin
         errors++;
         $display("FAIL reset: busy=%0b done=%0b prod=%0d err=%0b expected all 0", bus.Busy, bus.Done, bus.Prod, bus.Err);
      end
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      @(posedge Clk); #1;
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Prod !== 8'h00) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%0b done=%0b prod=%0d expected 0 0 0", bus.Busy, bus.Done, bus.Prod);
      end
      $display("op reset released");
   endtask

   task automatic test_basic();
      run_op(4'd3, 4'd4, 4'd2, "basic");
      run_op(4'd1, 4'd5, 4'd5, "rem_eq_div");
      run_op(4'hF, 4'd0, 4'hF, "zero_div");
   endtask

   task automatic test_back_to_back();
      run_op(4'd15, 4'd15, 4'd14, "max");
      run_op(4'd0, 4'd5, 4'd3, "b2b");
   endtask

   task automatic test_ignore_start();
      bus.Start = 1'b1; bus.q = 4'd2; bus.b = 4'd6; bus.r = 4'd1;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      @(posedge Clk); #1;
      bus.Start = 1'b1; bus.q = 4'd7; bus.b = 4'd7; bus.r = 4'd0;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      @(posedge Clk); #1;
      checks++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b1) begin
         errors++;
         $display("FAIL ignore_mid: busy=%0b done=%0b expected busy=1 done=0", bus.Busy, bus.Done);
      end
      @(posedge Clk); #1;
      checks++;
      if (bus.Done !== 1'b1 || bus.Prod !== 8'd13 || bus.Err !== model_err(4'd6, 4'd1)) begin
         errors++;
         $display("FAIL ignore_result: done=%0b prod=%0d err=%0b expected done=1 prod=13 err=%0b",
                  bus.Done, bus.Prod, bus.Err, model_err(4'd6, 4'd1));
      end
      @(posedge Clk); #1;
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b1) begin
         errors++;
         $display("FAIL ignore_not_queued: busy=%0b done=%0b expected busy=0 done=1", bus.Busy, bus.Done);
      end
      last_prod = 8'd13;
      $display("op ignore_start q=2 b=6 r=1 prod=%0d", bus.Prod);
   endtask

   task automatic test_start_held();
      logic exp_d;
      bus.Start = 1'b1; bus.q = 4'd1; bus.b = 4'd9; bus.r = 4'd3;
      for (int c = 0; c < 10; c++) begin
         @(posedge Clk); #1;
         exp_d = (c == 4) || (c == 9);
         checks++;
         if (bus.Done !== exp_d || (exp_d && bus.Prod !== 8'd12)) begin
            errors++;
            $display("FAIL start_held c%0d: done=%0b prod=%0d expected done=%0b prod=12", c, bus.Done, bus.Prod, exp_d);
         end
      end
      bus.Start = 1'b0;
      last_prod = 8'd12;
      $display("op start_held q=1 b=9 r=3 prod=%0d", bus.Prod);
   endtask

   task automatic test_async_reset();
      bus.Start = 1'b1; bus.q = 4'd9; bus.b = 4'd9; bus.r = 4'd2;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      @(posedge Clk); #3;
      Rst = 1'b1;
      #1;
      checks++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Prod !== 8'h00 || bus.Err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: busy=%0b done=%0b prod=%0d err=%0b expected all 0", bus.Busy, bus.Done, bus.Prod, bus.Err);
      end
      @(negedge Clk);
      Rst = 1'b0;
      last_prod = 8'h00;
      @(posedge Clk); #1;
      $display("op async_reset aborted");
      run_op(4'd2, 4'd3, 4'd0, "after_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) begin @(posedge Clk); #1; end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      last_prod = 8'h00;
      Rst = 1'b1;
      bus.Start = 1'b0; bus.q = 4'd0; bus.b = 4'd0; bus.r = 4'd0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_start();
      test_start_held();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion before 200000");
      $fatal(1, "timeout");
   end

endmodule
